// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS instruction into the ALU operand/control triple
// and holds it under stall/flush control with one cycle of latency.
module alu_issue_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic        o_valid,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   output logic [3:0]  o_alu_control,
   output logic [4:0]  o_dest_reg,
   output logic        o_reg_write,
   output logic        o_illegal
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_ADDU = 4'b0011;
   localparam logic [3:0] ALU_SUBU = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_XOR  = 4'b1101;

   typedef struct packed {
      logic        valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ctrl;
      logic [4:0]  dest;
      logic        reg_write;
      logic        illegal;
   } issue_t;

   logic [5:0]  opcode;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign opcode   = i_instr[31:26];
   assign rt_idx   = i_instr[20:16];
   assign rd_idx   = i_instr[15:11];
   assign shamt    = i_instr[10:6];
   assign funct    = i_instr[5:0];
   assign imm_sext = {{16{i_instr[15]}}, i_instr[15:0]};
   assign imm_zext = {16'h0000, i_instr[15:0]};

   issue_t      decoded;
   issue_t      issue_q;
   logic        legal;
   logic        writes;
   logic [4:0]  dest;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  ctrl;

   always_comb begin
      legal  = 1'b1;
      writes = 1'b1;
      dest   = rt_idx;
      op_a   = i_rs_data;
      op_b   = i_rt_data;
      ctrl   = ALU_AND;

      case (opcode)
         6'h00: begin
            dest = rd_idx;
            case (funct)
               6'h20: ctrl = ALU_ADD;
               6'h21: ctrl = ALU_ADDU;
               6'h22: ctrl = ALU_SUB;
               6'h23: ctrl = ALU_SUBU;
               6'h24: ctrl = ALU_AND;
               6'h25: ctrl = ALU_OR;
               6'h26: ctrl = ALU_XOR;
               6'h27: ctrl = ALU_NOR;
               6'h2A: ctrl = ALU_SLT;
               6'h2B: ctrl = ALU_SLTU;
               // The ALU shifts b by a[4:0], so the shift amount always travels in a.
               6'h00: begin ctrl = ALU_SLL; op_a = {27'd0, shamt}; end
               6'h02: begin ctrl = ALU_SRL; op_a = {27'd0, shamt}; end
               6'h03: begin ctrl = ALU_SRA; op_a = {27'd0, shamt}; end
               6'h04: begin ctrl = ALU_SLL; op_a = {27'd0, i_rs_data[4:0]}; end
               6'h06: begin ctrl = ALU_SRL; op_a = {27'd0, i_rs_data[4:0]}; end
               6'h07: begin ctrl = ALU_SRA; op_a = {27'd0, i_rs_data[4:0]}; end
               default: legal = 1'b0;
            endcase
         end
         6'h08: begin ctrl = ALU_ADD;  op_b = imm_sext; end
         6'h09: begin ctrl = ALU_ADDU; op_b = imm_sext; end
         6'h0A: begin ctrl = ALU_SLT;  op_b = imm_sext; end
         6'h0B: begin ctrl = ALU_SLTU; op_b = imm_sext; end
         6'h0C: begin ctrl = ALU_AND;  op_b = imm_zext; end
         6'h0D: begin ctrl = ALU_OR;   op_b = imm_zext; end
         6'h0E: begin ctrl = ALU_XOR;  op_b = imm_zext; end
         6'h0F: begin ctrl = ALU_SLL;  op_a = 32'd16; op_b = imm_zext; end
         6'h23: begin ctrl = ALU_ADDU; op_b = imm_sext; end
         6'h2B: begin ctrl = ALU_ADDU; op_b = imm_sext; writes = 1'b0; end
         6'h04, 6'h05: begin ctrl = ALU_SUBU; writes = 1'b0; end
         default: legal = 1'b0;
      endcase

      decoded           = '0;
      decoded.valid     = 1'b1;
      decoded.illegal   = ~legal;
      if (legal) begin
         decoded.a         = op_a;
         decoded.b         = op_b;
         decoded.ctrl      = ctrl;
         // Non-writing instructions carry no destination so downstream hazard logic sees none.
         decoded.dest      = writes ? dest : 5'd0;
         decoded.reg_write = writes && (dest != 5'd0);
      end
   end

   // o_valid qualifies every output; there is no backpressure, i_stall simply freezes
   // the register and i_flush (which overrides i_stall) loads a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_q <= '0;
      end else if (i_flush) begin
         issue_q <= '0;
      end else if (!i_stall) begin
         issue_q <= i_valid ? decoded : '0;
      end
   end

   assign o_valid       = issue_q.valid;
   assign o_alu_a       = issue_q.a;
   assign o_alu_b       = issue_q.b;
   assign o_alu_control = issue_q.ctrl;
   assign o_dest_reg    = issue_q.dest;
   assign o_reg_write   = issue_q.reg_write;
   assign o_illegal     = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: drives one instruction per step, pushes the
// expected registered result to a queue and pops/compares it one cycle later.
module tb_alu_issue_stage;

   localparam int W = 76;
   localparam logic [W-1:0] NO_DEST_MASK = ~({{(W-5){1'b0}}, 5'h1F} << 2);

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic [31:0] i_instr;
   logic [31:0] i_rs_data;
   logic [31:0] i_rt_data;
   logic        i_stall;
   logic        i_flush;
   logic        o_valid;
   logic [31:0] o_alu_a;
   logic [31:0] o_alu_b;
   logic [3:0]  o_alu_control;
   logic [4:0]  o_dest_reg;
   logic        o_reg_write;
   logic        o_illegal;

   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr),
      .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_stall(i_stall), .i_flush(i_flush),
      .o_valid(o_valid), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_control(o_alu_control),
      .o_dest_reg(o_dest_reg), .o_reg_write(o_reg_write), .o_illegal(o_illegal)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] pack(input logic v, input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] ctrl, input logic [4:0] dest,
                                         input logic rw, input logic ill);
      return {v, a, b, ctrl, dest, rw, ill};
   endfunction

   function automatic logic [W-1:0] observed();
      return {o_valid, o_alu_a, o_alu_b, o_alu_control, o_dest_reg, o_reg_write, o_illegal};
   endfunction

   // scoreboard: pop the oldest expectation and compare; dest is only meaningful for writers
   task automatic check_output(input string tag);
      logic [W-1:0] exp_v;
      logic [W-1:0] obs_v;
      logic [W-1:0] mask;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=no-expectation required=queued-entry", tag);
         return;
      end
      exp_v = exp_q.pop_front();
      mask  = exp_v[1] ? {W{1'b1}} : NO_DEST_MASK;
      obs_v = observed() & mask;
      exp_v = exp_v & mask;
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h required=%h", tag, obs_v, exp_v);
      end
   endtask

   // driver: present inputs on the falling edge, expect the result after the next rising edge
   task automatic step(input logic v, input logic stall, input logic flush,
                       input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [W-1:0] exp_v, input string tag);
      @(negedge clk);
      i_valid   = v;
      i_stall   = stall;
      i_flush   = flush;
      i_instr   = instr;
      i_rs_data = rs;
      i_rt_data = rt;
      exp_q.push_back(exp_v);
      @(posedge clk);
      #1;
      check_output(tag);
   endtask

   logic [W-1:0] slt_exp;
   logic [31:0]  r1;
   logic [31:0]  r2;

   initial begin
      rst_n     = 1'b0;
      i_valid   = 1'b0;
      i_stall   = 1'b0;
      i_flush   = 1'b0;
      i_instr   = 32'h0;
      i_rs_data = 32'h0;
      i_rt_data = 32'h0;
      #3;
      exp_q.push_back('0);
      check_output("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      step(1, 0, 0, 32'h00221820, 32'd10, 32'd5, pack(1, 32'd10, 32'd5, 4'b0010, 5'd3, 1, 0), "add");
      step(1, 0, 0, 32'h000220C3, 32'h0, 32'hFFFFFFF0,
           pack(1, 32'd3, 32'hFFFFFFF0, 4'b1011, 5'd4, 1, 0), "sra");
      step(1, 0, 0, 32'h2025FFFF, 32'd7, 32'd0, pack(1, 32'd7, 32'hFFFFFFFF, 4'b0010, 5'd5, 1, 0), "addi_neg");
      step(1, 0, 0, 32'h3425FFFF, 32'd7, 32'd0, pack(1, 32'd7, 32'h0000FFFF, 4'b0001, 5'd5, 1, 0), "ori_zext");
      step(1, 0, 0, 32'h3C061234, 32'd99, 32'd0, pack(1, 32'd16, 32'h00001234, 4'b1000, 5'd6, 1, 0), "lui");
      step(1, 0, 0, 32'hAC220004, 32'd100, 32'd42, pack(1, 32'd100, 32'd4, 4'b0011, 5'd0, 0, 0), "sw");
      step(1, 0, 0, 32'h10220008, 32'd5, 32'd5, pack(1, 32'd5, 32'd5, 4'b0100, 5'd0, 0, 0), "beq");
      step(1, 0, 0, 32'hFC000000, 32'd1, 32'd2, pack(1, 32'd0, 32'd0, 4'b0000, 5'd0, 0, 1), "illegal_opcode");
      step(1, 0, 0, 32'h00221801, 32'd1, 32'd2, pack(1, 32'd0, 32'd0, 4'b0000, 5'd0, 0, 1), "illegal_funct");
      step(1, 0, 0, 32'h00223804, 32'h00000025, 32'h0000F000,
           pack(1, 32'd5, 32'h0000F000, 4'b1000, 5'd7, 1, 0), "sllv");
      step(1, 0, 0, 32'h00000000, 32'h0, 32'h55, pack(1, 32'd0, 32'h55, 4'b1000, 5'd0, 0, 0), "nop_sll");
      step(1, 0, 0, 32'h2C298000, 32'd3, 32'd0, pack(1, 32'd3, 32'hFFFF8000, 4'b1001, 5'd9, 1, 0), "sltiu");
      step(1, 0, 0, 32'h00225027, 32'hA5A5, 32'h5A5A, pack(1, 32'hA5A5, 32'h5A5A, 4'b1100, 5'd10, 1, 0), "nor");
      step(1, 0, 0, 32'h00220021, 32'd1, 32'd2, pack(1, 32'd1, 32'd2, 4'b0011, 5'd0, 0, 0), "addu_dest0");
      step(0, 0, 0, 32'h00221820, 32'd1, 32'd2, '0, "invalid_bubble");

      for (int i = 0; i < 4; i++) begin
         r1 = $urandom_range(0, 32'hFFFF_FFFF);
         r2 = $urandom_range(0, 32'hFFFF_FFFF);
         step(1, 0, 0, 32'h00225821, r1, r2, pack(1, r1, r2, 4'b0011, 5'd11, 1, 0), "addu_rand");
      end

      slt_exp = pack(1, 32'd3, 32'd9, 4'b0111, 5'd8, 1, 0);
      step(1, 0, 0, 32'h0022402A, 32'd3, 32'd9, slt_exp, "slt");
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 32'h00221820, 32'd77, 32'd88, slt_exp, "stall_hold");
      step(1, 1, 1, 32'h00221820, 32'd77, 32'd88, '0, "stall_flush");
      step(1, 0, 0, 32'h00221820, 32'd10, 32'd5, pack(1, 32'd10, 32'd5, 4'b0010, 5'd3, 1, 0), "add_after_flush");

      // asynchronous reset while stalled: outputs must clear before any clock edge
      @(negedge clk);
      i_stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back('0);
      check_output("async_reset_mid_stall");
      @(negedge clk);
      rst_n   = 1'b1;
      i_stall = 1'b0;
      exp_q.push_back('0);
      check_output("reset_held_no_state");
      step(1, 0, 0, 32'h0022402A, 32'd3, 32'd9, slt_exp, "slt_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
